// File: rtl/vc_pop_demux.sv
// Pops the main FIFO and routes each word to VC0 or VC1 by its class bit.
// Latency: pop_main to push_vcX is 2 cycles; one word per cycle sustained.
// Backpressure: pause on either VC, or an empty main FIFO, stops popping in the same cycle.
//
// Ports:
//   clk, reset_L            clock and synchronous active-low reset
//   enable                  1 = pop and route, 0 = stop popping and drain in-flight words
//   fifo_empty_main         main FIFO empty flag
//   data_demux_vc           main FIFO registered read data (valid the cycle after pop_main)
//   pause_vc0/1, full_vc0/1 VC FIFO almost-full / full flags
//   pop_main                combinational pop request to the main FIFO
//   push_vc0/1, data_vc0/1  registered push strobes and write data to each VC FIFO
//   count_vc0/1             words routed per VC, wrapping modulo 2^CNT_WIDTH
//   idle                    FSM idle with empty pipeline
//   error_demux             sticky: a push was issued into a full VC FIFO
module vc_pop_demux #(
    parameter int DATA_SIZE = 6,
    parameter int CLASS_BIT = DATA_SIZE - 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty_main,
    input  logic [DATA_SIZE-1:0] data_demux_vc,
    input  logic                 pause_vc0,
    input  logic                 pause_vc1,
    input  logic                 full_vc0,
    input  logic                 full_vc1,
    output logic                 pop_main,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc0,
    output logic [DATA_SIZE-1:0] data_vc1,
    output logic [CNT_WIDTH-1:0] count_vc0,
    output logic [CNT_WIDTH-1:0] count_vc1,
    output logic                 idle,
    output logic                 error_demux
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pop_d;
    logic   word_class;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            // Re-enable wins over finishing the drain.
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (!pop_d) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Both pauses gate the pop: the destination of a word is unknown until
    // it has been read out of the main FIFO.
    assign pop_main = reset_L & (state == RUN) & enable & ~fifo_empty_main
                      & ~pause_vc0 & ~pause_vc1;

    assign word_class = data_demux_vc[CLASS_BIT];

    assign idle = (state == IDLE) & ~pop_d & ~push_vc0 & ~push_vc1;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state       <= IDLE;
            pop_d       <= 1'b0;
            push_vc0    <= 1'b0;
            push_vc1    <= 1'b0;
            data_vc0    <= '0;
            data_vc1    <= '0;
            count_vc0   <= '0;
            count_vc1   <= '0;
            error_demux <= 1'b0;
        end else begin
            state    <= state_nxt;
            pop_d    <= pop_main;
            push_vc0 <= pop_d & ~word_class;
            push_vc1 <= pop_d & word_class;
            if (pop_d && !word_class) begin
                data_vc0  <= data_demux_vc;
                count_vc0 <= count_vc0 + CNT_WIDTH'(1);
            end
            if (pop_d && word_class) begin
                data_vc1  <= data_demux_vc;
                count_vc1 <= count_vc1 + CNT_WIDTH'(1);
            end
            // The push into a full FIFO is still issued; only the flag records it.
            error_demux <= error_demux | (push_vc0 & full_vc0) | (push_vc1 & full_vc1);
        end
    end

endmodule

// File: tb/tb_vc_pop_demux.sv
// Bench for vc_pop_demux: behavioural main-FIFO queue plus a cycle-indexed
// table of expected pushes, expected counts and sticky error.
module tb_vc_pop_demux;
    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          enable;
    logic          fifo_empty_main;
    logic [DW-1:0] data_demux_vc;
    logic          pause_vc0, pause_vc1, full_vc0, full_vc1;
    logic          pop_main, push_vc0, push_vc1;
    logic [DW-1:0] data_vc0, data_vc1;
    logic [CW-1:0] count_vc0, count_vc1;
    logic          idle, error_demux;

    always #5 clk = ~clk;

    vc_pop_demux #(.DATA_SIZE(DW), .CLASS_BIT(DW-1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .fifo_empty_main(fifo_empty_main), .data_demux_vc(data_demux_vc),
        .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
        .full_vc0(full_vc0), .full_vc1(full_vc1),
        .pop_main(pop_main), .push_vc0(push_vc0), .push_vc1(push_vc1),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .count_vc0(count_vc0), .count_vc1(count_vc1),
        .idle(idle), .error_demux(error_demux)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference state
    logic [DW-1:0] mainq[$];
    logic [DW-1:0] sched[int];   // cycle number -> word expected to be pushed then
    bit            en_prev = 1'b0;
    bit            exp_err = 1'b0;
    int            exp_cnt0 = 0, exp_cnt1 = 0;
    logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;
    int            pops_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        mainq.push_back(w);
        fifo_empty_main = 1'b0;
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the
    // FIFO environment and the reference model across the rising edge.
    task automatic cycle();
        bit            exp_pop, exp_p0, exp_p1, popped;
        logic [DW-1:0] w;
        logic [DW-1:0] rw;
        @(negedge clk);
        exp_pop = reset_L && enable && en_prev && (mainq.size() != 0) && !pause_vc0 && !pause_vc1;
        exp_p0 = 1'b0;
        exp_p1 = 1'b0;
        if (sched.exists(cyc)) begin
            w = sched[cyc];
            sched.delete(cyc);
            if (w[DW-1]) begin
                exp_p1 = 1'b1; exp_d1 = w; exp_cnt1 = (exp_cnt1 + 1) % 256;
            end else begin
                exp_p0 = 1'b1; exp_d0 = w; exp_cnt0 = (exp_cnt0 + 1) % 256;
            end
        end
        check("pop_main", 32'(pop_main), 32'(exp_pop));
        check("push_vc0", 32'(push_vc0), 32'(exp_p0));
        check("push_vc1", 32'(push_vc1), 32'(exp_p1));
        check("data_vc0", 32'(data_vc0), 32'(exp_d0));
        check("data_vc1", 32'(data_vc1), 32'(exp_d1));
        check("count_vc0", 32'(count_vc0), 32'(exp_cnt0));
        check("count_vc1", 32'(count_vc1), 32'(exp_cnt1));
        check("error_demux", 32'(error_demux), 32'(exp_err));
        popped = 1'b0;
        rw = '0;
        if (pop_main && mainq.size() != 0) begin
            rw = mainq.pop_front();
            sched[cyc + 2] = rw;
            popped = 1'b1;
            pops_seen++;
        end
        if ((exp_p0 && full_vc0) || (exp_p1 && full_vc1)) exp_err = 1'b1;
        en_prev = reset_L && enable;
        if (!reset_L) begin
            sched.delete();
            exp_err = 1'b0;
            exp_cnt0 = 0; exp_cnt1 = 0;
            exp_d0 = '0;  exp_d1 = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (popped) data_demux_vc = rw;
        fifo_empty_main = (mainq.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        cycle();
        reset_L = 1'b1;
    endtask

    initial begin
        int start_pops, c0, c1, p0;
        logic [DW-1:0] w;
        reset_L = 1'b0; enable = 1'b0; fifo_empty_main = 1'b1; data_demux_vc = '0;
        pause_vc0 = 1'b0; pause_vc1 = 1'b0; full_vc0 = 1'b0; full_vc1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, still in reset, then released
        cycle();
        reset_L = 1'b1;
        cycle();
        check("idle_after_reset", 32'(idle), 32'd1);

        // Directed: 0x05 -> VC0, 0x21 -> VC1, 0x03 -> VC0
        load(6'h05); load(6'h21); load(6'h03);
        enable = 1'b1;
        cycle();
        check("idle_while_enabled", 32'(idle), 32'd0);
        run(5);
        check("directed_cnt0", 32'(count_vc0), 32'd2);
        check("directed_cnt1", 32'(count_vc1), 32'd1);
        check("directed_idle_en", 32'(idle), 32'd0);

        // Pause on VC1 raised right after the second pop of a 6-word stream
        start_pops = pops_seen;
        for (int i = 0; i < 6; i++) load(6'($urandom));
        for (int i = 0; i < 20 && (pops_seen - start_pops) < 2; i++) cycle();
        pause_vc1 = 1'b1;
        run(6);
        check("pause_pops_held", 32'(pops_seen - start_pops), 32'd2);
        pause_vc1 = 1'b0;
        run(8);
        check("pause_all_popped", 32'(pops_seen - start_pops), 32'd6);

        // Enable dropped mid-stream: drain, idle two cycles later
        c0 = count_vc0; c1 = count_vc1;
        start_pops = pops_seen;
        for (int i = 0; i < 8; i++) load(6'($urandom));
        run(3);
        enable = 1'b0;
        cycle();
        cycle();
        check("drain_idle", 32'(idle), 32'd1);
        check("drain_totals", 32'((count_vc0 + count_vc1 - c0 - c1) % 256),
              32'((pops_seen - start_pops) % 256));
        run(2);

        // Push into a full VC0: sticky error until reset
        mainq.delete();
        fifo_empty_main = 1'b1;
        enable = 1'b1;
        load(6'h0A); load(6'h11);
        full_vc0 = 1'b1;
        run(5);
        full_vc0 = 1'b0;
        check("err_set", 32'(error_demux), 32'd1);
        for (int i = 0; i < 4; i++) load(6'($urandom));
        run(8);
        check("err_sticky", 32'(error_demux), 32'd1);
        do_reset();
        cycle();
        check("err_cleared", 32'(error_demux), 32'd0);

        // 256 VC0 words: counter wraps back to 0
        mainq.delete();
        fifo_empty_main = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 6'($urandom);
            w[DW-1] = 1'b0;
            load(w);
        end
        run(262);
        check("wrap_cnt0", 32'(count_vc0), 32'd0);
        check("wrap_cnt1", 32'(count_vc1), 32'd0);

        // Reset with two words in flight
        for (int i = 0; i < 5; i++) load(6'($urandom));
        run(3);
        p0 = pops_seen;
        reset_L = 1'b0;
        cycle();
        reset_L = 1'b1;
        enable = 1'b0;
        check("rst_cnt0", 32'(count_vc0), 32'd0);
        check("rst_data0", 32'(data_vc0), 32'd0);
        check("rst_push0", 32'(push_vc0), 32'd0);
        run(3);
        check("rst_no_pop", 32'(pops_seen), 32'(p0));
        check("rst_idle", 32'(idle), 32'd1);
        mainq.delete();
        fifo_empty_main = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(99) < 85);
            pause_vc0 = ($urandom_range(99) < 12);
            pause_vc1 = ($urandom_range(99) < 12);
            full_vc0  = ($urandom_range(99) < 5);
            full_vc1  = ($urandom_range(99) < 5);
            reset_L   = ($urandom_range(999) >= 5);
            if (mainq.size() < 16 && $urandom_range(99) < 60) load(6'($urandom));
            cycle();
        end
        reset_L = 1'b1; enable = 1'b0;
        pause_vc0 = 1'b0; pause_vc1 = 1'b0; full_vc0 = 1'b0; full_vc1 = 1'b0;
        run(4);
        check("final_idle", 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vc_pop_demux.md
# vc_pop_demux

Read-side controller for the main FIFO. It pops words whenever the FIFO is non-empty and neither virtual-channel FIFO is pausing. It captures each popped word from the main FIFO's registered read port and routes it to VC0 or VC1 by a class bit, asserting a one-cycle push on the selected channel. It sits between the main FIFO and the two VC FIFOs, and provides enable/drain control, per-VC word counters and a sticky overflow error.

## Interface
- DATA_SIZE, 6, word width; matches the main FIFO data width.
- CLASS_BIT, DATA_SIZE-1, bit index selecting the destination (0 → VC0, 1 → VC1).
- CNT_WIDTH, 8, width of each per-VC routed-word counter.

- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  synchronous active-low reset.
- enable  input  1  1 = pop and route; 0 = stop popping and drain in-flight words.
- fifo_empty_main  input  1  main FIFO empty flag.
- data_demux_vc  input  DATA_SIZE  main FIFO registered read data; holds the popped word in the cycle after pop_main.
- pause_vc0, pause_vc1  input  1  VC FIFO almost-full flags.
- full_vc0, full_vc1  input  1  VC FIFO full flags.
- pop_main  output  1  pop request to the main FIFO (combinational).
- push_vc0, push_vc1  output  1  registered one-cycle push strobes.
- data_vc0, data_vc1  output  DATA_SIZE  registered write data to each VC FIFO.
- count_vc0, count_vc1  output  CNT_WIDTH  words routed per VC.
- idle  output  1  1 = FSM in IDLE and pipeline empty.
- error_demux  output  1  sticky overflow flag.

## Operation
- FSM states: IDLE, RUN, DRAIN. The state register is reset to IDLE.
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → IDLE when pop_d=0 (pop_d is the pop_main value delayed one cycle).
  - DRAIN → RUN when enable=1 again. This takes priority over the DRAIN → IDLE transition.
- pop_main = reset_L & (state==RUN) & enable & !fifo_empty_main & !pause_vc0 & !pause_vc1.
  - Pausing on either VC is required because the destination of a word is unknown until it has been popped.
- pop_d register: pop_d <= pop_main.
- When pop_d=1, the block samples data_demux_vc and evaluates w[CLASS_BIT]:
  - w[CLASS_BIT]=0: push_vc0<=1, data_vc0<=w, count_vc0 increments.
  - w[CLASS_BIT]=1: push_vc1<=1, data_vc1<=w, count_vc1 increments.
  - The push strobe on the unselected VC is 0. Its data output holds its last value.
- When pop_d=0, both push strobes are 0 and both data outputs hold.
- Counters are modulo 2^CNT_WIDTH and wrap silently from all-ones to 0.
- error_demux is set on the edge after any cycle where push_vcX=1 and full_vcX=1. It stays set until reset. The push is still issued; the block does not drop or retry it.
- idle = (state==IDLE) & !pop_d & !push_vc0 & !push_vc1.
- Integration requirement: each VC's almost-full threshold must leave at least 2 free entries. Up to 2 words can be in flight after a pause rises.

## Timing
- Reset (reset_L=0 at an edge) sets:
  - state=IDLE, pop_d=0, push_vc0/1=0, data_vc0/1=0, count_vc0/1=0, error_demux=0.
  - idle=1 once reset is released.
  - pop_main is 0 for as long as reset_L=0.
- Reset mid-operation discards any in-flight words. No push is issued for them.
- Latency:
  - cycle N: pop_main=1.
  - cycle N+1: data_demux_vc holds the word and pop_d=1.
  - cycle N+2: push_vcX=1 with data_vcX=word, and count_vcX is updated.
  - Pop to push = 2 cycles.
- Throughput: one word per cycle while unpaused. Back-to-back pops produce back-to-back pushes, and consecutive pushes may go to different VCs.
- Pause or empty asserted in cycle N: pop_main=0 in cycle N. Words popped in N-1 and N-2 still complete.
- enable deasserted in cycle N: pop_main=0 from cycle N. idle=1 no later than cycle N+2.
- fifo_empty_main=1 together with RUN gives no pop. The block never underflows the main FIFO.

## Test plan
- Reset, then enable=1 with the main FIFO loaded with 0x05, 0x21, 0x03 and all pauses low → pop_main high for 3 cycles. Expected pushes, starting 2 cycles later:
  - push_vc0 with 0x05;
  - push_vc1 with 0x21;
  - push_vc0 with 0x03;
  - final counts count_vc0=2, count_vc1=1; idle=0 while enabled.
- Streaming 6 words with pause_vc1 raised after the 2nd pop → pop_main drops the same cycle. The 2 in-flight words are still pushed; no further push occurs until the pause clears, then the remaining 4 words stream in order.
- enable dropped mid-stream → FSM enters DRAIN; exactly the in-flight words are pushed; idle=1 within 2 cycles; count totals equal the number of pops.
- full_vc0=1 while a VC0 push is issued → error_demux=1 on the next edge and remains set through later traffic until reset_L=0.
- 256 VC0 words with CNT_WIDTH=8 → count_vc0 wraps to 0.
- reset_L=0 with 2 words in flight → no push issued for them; all outputs return to their reset values.
